// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer: drop-counter width and saturation value.
// Latency: none; this file holds only constants and a configuration check helper.
// Backpressure: none.
package demux_pkg;

   localparam int DROP_CNT_W = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

   localparam int N_CH_MIN   = 2;
   localparam int N_CH_MAX   = 64;
   localparam int DATA_W_MIN = 1;
   localparam int DATA_W_MAX = 64;

   function automatic bit demux_cfg_ok(int n_ch, int data_w);
      return (n_ch >= N_CH_MIN) && (n_ch <= N_CH_MAX) &&
             (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register: a valid bit plus a data word, loaded by the demux and popped by the consumer.
// Latency: a load is visible on valid/data_out after the loading edge.
// Backpressure: load beats pop in the same cycle; data_out holds its last value once empty.
module demux_slot #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] data_out
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         data_out <= '0;
      end else if (load) begin
         valid    <= 1'b1;
         data_out <= data_in;
      end else if (pop) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_stream_1xn.sv
// 1-to-N stream demux: each word goes to the slot named by in_sel; DEMUX_DROP_CNT_EN adds drop_cnt.
// Latency: word accepted at edge k appears on out_valid/out_data after edge k; one word per cycle.
// Backpressure: in_ready drops only when the selected slot is full and not being drained, or en=0.
module demux_stream_1xn
   import demux_pkg::*;
#(
   parameter int N_CH   = 16,
   parameter int DATA_W = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic [DATA_W-1:0]      in_data,
   output logic [N_CH-1:0]        out_valid,
   input  logic [N_CH-1:0]        out_ready,
`ifdef DEMUX_DROP_CNT_EN
   output logic [N_CH*DATA_W-1:0] out_data,
   output logic [DROP_CNT_W-1:0]  drop_cnt
`else
   output logic [N_CH*DATA_W-1:0] out_data
`endif
);

   localparam int N_PAD = 1 << SEL_W;
   localparam logic [SEL_W:0] N_CH_V = (SEL_W+1)'(N_CH);

   if (!demux_cfg_ok(N_CH, DATA_W)) begin : g_bad_cfg
      $error("demux_stream_1xn: N_CH or DATA_W out of supported range");
   end

   logic             sel_hit;
   logic             in_xfer;
   logic [N_PAD-1:0] vld_ext;
   logic [N_PAD-1:0] rdy_ext;

   // Pad to a power of two so an out-of-range in_sel still indexes a defined bit.
   always_comb begin
      vld_ext = '0;
      rdy_ext = '0;
      vld_ext[N_CH-1:0] = out_valid;
      rdy_ext[N_CH-1:0] = out_ready;
   end

   assign sel_hit  = ({1'b0, in_sel} < N_CH_V);
   assign in_ready = en && (!sel_hit || !vld_ext[in_sel] || rdy_ext[in_sel]);
   assign in_xfer  = in_valid && in_ready;

   for (genvar i = 0; i < N_CH; i++) begin : g_slot
      demux_slot #(.DATA_W(DATA_W)) u_slot (
         .clk      (clk),
         .rst      (rst),
         .load     (in_xfer && sel_hit && (in_sel == SEL_W'(i))),
         .data_in  (in_data),
         .pop      (out_valid[i] && out_ready[i]),
         .valid    (out_valid[i]),
         .data_out (out_data[i*DATA_W +: DATA_W])
      );
   end

`ifdef DEMUX_DROP_CNT_EN
   // Words addressed past the last channel are consumed here and only counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (in_xfer && !sel_hit && (drop_cnt != DROP_CNT_MAX)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: a 16-channel instance checked every cycle against a slot model,
// plus a 12-channel instance for out-of-range selects; drop_cnt checks exist with DEMUX_DROP_CNT_EN.
module tb_demux_stream_1xn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, en, in_valid, in_ready;
   logic [3:0]   in_sel;
   logic [7:0]   in_data;
   logic [15:0]  out_valid, out_ready;
   logic [127:0] out_data;

   logic         en12, in_valid12, in_ready12;
   logic [3:0]   in_sel12;
   logic [7:0]   in_data12;
   logic [11:0]  out_valid12, out_ready12;
   logic [95:0]  out_data12;
`ifdef DEMUX_DROP_CNT_EN
   logic [15:0]  drop_cnt, drop_cnt12;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   demux_stream_1xn #(.N_CH(16), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
`ifdef DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   demux_stream_1xn #(.N_CH(12), .DATA_W(8)) dut12 (
      .clk(clk), .rst(rst), .en(en12), .in_valid(in_valid12), .in_ready(in_ready12),
      .in_sel(in_sel12), .in_data(in_data12), .out_valid(out_valid12),
      .out_ready(out_ready12), .out_data(out_data12)
`ifdef DEMUX_DROP_CNT_EN
      , .drop_cnt(drop_cnt12)
`endif
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of the 16-channel instance: one mailbox per channel, filled by accepted words.
   logic       m_vld [16];
   logic [7:0] m_dat [16];

   function automatic logic m_ready();
      return en && (!m_vld[in_sel] || out_ready[in_sel]);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_vld[i] <= 1'b0;
            m_dat[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < 16; i++)
            if (m_vld[i] && out_ready[i]) m_vld[i] <= 1'b0;
         if (in_valid && m_ready()) begin
            m_vld[in_sel] <= 1'b1;
            m_dat[in_sel] <= in_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         logic [15:0]  ev;
         logic [127:0] ed;
         for (int i = 0; i < 16; i++) begin
            ev[i] = m_vld[i];
            ed[i*8 +: 8] = m_dat[i];
         end
         chk("model_in_ready", in_ready, m_ready());
         chk("model_out_valid", out_valid, ev);
         chk("model_out_data", out_data, ed);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_sel = 4'd2; in_data = 8'hFF; out_ready = '1;
      en12 = 1'b1; in_valid12 = 1'b1; in_sel12 = 4'd1; in_data12 = 8'hEE; out_ready12 = '1;
      tick();
      chk_on = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_valid12", out_valid12, 0);
      chk("rst_data12", out_data12, 0);
`ifdef DEMUX_DROP_CNT_EN
      chk("rst_drop12", drop_cnt12, 0);
`endif
      rst = 1'b0; in_valid = 1'b0; in_valid12 = 1'b0;
      tick();

      // Routing sweep, all consumers ready
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_sel = 4'(i); in_data = 8'hA0 + 8'(i);
         @(negedge clk);
         chk("sweep_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("sweep_valid", out_valid, 16'h8000);
      chk("sweep_d15", out_data[127:120], 8'hAF);
      chk("sweep_d7", out_data[63:56], 8'hA7);
      chk("sweep_d0", out_data[7:0], 8'hA0);
      tick();

      // Backpressure on channel 3, channel 5 unaffected
      out_ready[3] = 1'b0;
      in_valid = 1'b1; in_sel = 4'd3; in_data = 8'h31;
      tick();
      in_sel = 4'd5; in_data = 8'h51;
      @(negedge clk);
      chk("bp_ch5_ready", in_ready, 1);
      tick();
      in_sel = 4'd3; in_data = 8'h32;
      @(negedge clk);
      chk("bp_block", in_ready, 0);
      chk("bp_hold", out_data[31:24], 8'h31);
      chk("bp_valid3", out_valid[3], 1);
      tick();
      @(negedge clk);
      chk("bp_block2", in_ready, 0);
      out_ready[3] = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_deliver", out_data[31:24], 8'h32);
      chk("bp_deliver_v", out_valid[3], 1);
      tick();

      // Simultaneous drain and load on channel 7
      out_ready[7] = 1'b0;
      in_valid = 1'b1; in_sel = 4'd7; in_data = 8'h70;
      tick();
      in_data = 8'h55; out_ready[7] = 1'b1;
      @(negedge clk);
      chk("dl_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("dl_valid", out_valid[7], 1);
      chk("dl_data", out_data[63:56], 8'h55);
      tick();
      @(negedge clk);
      chk("dl_drained", out_valid[7], 0);
      tick();

      // Enable low blocks loads while channel 9 still drains
      out_ready[9] = 1'b0;
      in_valid = 1'b1; in_sel = 4'd9; in_data = 8'h90;
      tick();
      en = 1'b0; in_sel = 4'd10; in_data = 8'hAA;
      @(negedge clk);
      chk("en_block", in_ready, 0);
      out_ready[9] = 1'b1;
      tick();
      @(negedge clk);
      chk("en_drain", out_valid[10:9], 2'b00);
      en = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("en_resume_v", out_valid[10], 1);
      chk("en_resume_d", out_data[87:80], 8'hAA);
      tick();

      // Reset with a word pending and a transfer in the reset cycle
      out_ready[1] = 1'b0;
      in_valid = 1'b1; in_sel = 4'd1; in_data = 8'h11;
      tick();
      rst = 1'b1; in_sel = 4'd2; in_data = 8'h22;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = '1;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      tick();

      // Out-of-range selects on the 12-channel instance
      in_valid12 = 1'b1; in_sel12 = 4'd13; in_data12 = 8'hD0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("oor_ready", in_ready12, 1);
         tick();
      end
      in_sel12 = 4'd11; in_data12 = 8'h0B;
      @(negedge clk);
      chk("oor_none", out_valid12, 0);
`ifdef DEMUX_DROP_CNT_EN
      chk("oor_drop3", drop_cnt12, 3);
      chk("oor_drop16", drop_cnt, 0);
`endif
      tick();
      in_valid12 = 1'b0;
      @(negedge clk);
      chk("oor_valid11", out_valid12, 12'h800);
      chk("oor_d11", out_data12[95:88], 8'h0B);
      tick();

`ifdef DEMUX_DROP_CNT_EN
      in_valid12 = 1'b1; in_sel12 = 4'd13;
      repeat (65531) @(posedge clk);
      #1;
      @(negedge clk);
      chk("sat_fffe", drop_cnt12, 16'hFFFE);
      tick();
      tick();
      @(negedge clk);
      chk("sat_ffff", drop_cnt12, 16'hFFFF);
      in_valid12 = 1'b0;
      tick();
`endif

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
